// File: rtl/neuron_acc_if.sv
// Handshake bundle between the neuron feeder and its upstream/downstream
// neighbours: pair input side plus the quantised address strobe.
interface neuron_acc_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] w_in;
    logic                     in_ready;
    logic        [ADDR_W-1:0] addr;
    logic                     addr_valid;
    logic                     sat;
    logic                     busy;

    modport master (
        output start, in_valid, x_in, w_in,
        input  in_ready, addr, addr_valid, sat, busy
    );

    modport slave (
        input  start, in_valid, x_in, w_in,
        output in_ready, addr, addr_valid, sat, busy
    );
endinterface

// File: rtl/neuron_acc.sv
// Single-neuron dot-product accumulator: sums N_INPUTS signed products, then
// scales, saturates and offsets the sum into an activation-memory address.
module neuron_acc #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 36,
    parameter int SHIFT    = 20,
    parameter int ADDR_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    neuron_acc_if.slave  bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(N_INPUTS + 1);
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 <<< (ADDR_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-(1 <<< (ADDR_W - 1)));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        QUANT = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                    state_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;
    logic        [CNT_W-1:0]   count_q;
    logic        [CNT_W-1:0]   count_d;
    logic        [ADDR_W-1:0]  addr_q;
    logic                      sat_q;
    logic                      addr_valid_q;
    logic                      in_ready_q;
    logic                      busy_q;

    logic signed [PROD_W-1:0]  prod_s;
    logic                      accept_s;
    logic                      last_s;
    logic        [ADDR_W:0]    quant_s;

    // Floor shift, clip to the signed address range, then flip the MSB to
    // turn two's complement into offset binary. Result is {clipped, addr}.
    function automatic logic [ADDR_W:0] quantize(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W-1:0] s;
        logic        [ADDR_W-1:0] q;
        logic                     clip;
        s = sum >>> SHIFT;
        if (s > Q_MAX) begin
            q    = Q_MAX[ADDR_W-1:0];
            clip = 1'b1;
        end else if (s < Q_MIN) begin
            q    = Q_MIN[ADDR_W-1:0];
            clip = 1'b1;
        end else begin
            q    = s[ADDR_W-1:0];
            clip = 1'b0;
        end
        return {clip, q ^ {1'b1, {(ADDR_W-1){1'b0}}}};
    endfunction

    // Product, accumulate and quantise datapath feeding the state register.
    always_comb begin
        prod_s   = PROD_W'(bus.x_in) * PROD_W'(bus.w_in);
        accept_s = bus.in_valid && in_ready_q;
        acc_d    = acc_q + ACC_W'(prod_s);
        count_d  = count_q + CNT_W'(1);
        last_s   = (count_q == CNT_W'(N_INPUTS - 1));
        quant_s  = quantize(acc_q);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            sat_q        <= 1'b0;
            addr_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    addr_valid_q <= 1'b0;
                    if (bus.start) begin
                        acc_q      <= '0;
                        count_q    <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ACC;
                    end else begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                ACC: begin
                    if (accept_s) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        if (last_s) begin
                            in_ready_q <= 1'b0;
                            state_q    <= QUANT;
                        end
                    end
                end
                QUANT: begin
                    addr_q       <= quant_s[ADDR_W-1:0];
                    sat_q        <= quant_s[ADDR_W];
                    addr_valid_q <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: begin
                    addr_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    addr_valid_q <= 1'b0;
                    in_ready_q   <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.addr       = addr_q;
    assign bus.addr_valid = addr_valid_q;
    assign bus.sat        = sat_q;
    assign bus.busy       = busy_q;
endmodule
